// File: rtl/fft256_spec_reader.sv
// Spectrum unloader: walks bins 0..N-1 of an external spectrum memory, presents each bin
// as a valid/ready beat with its squared magnitude, and tracks the peak-power bin per run.
//
// Ports:
//   ap_clk, ap_rst         clock, synchronous active-high reset
//   start, busy, done      run request, run in progress, one-cycle completion pulse
//   rd_en, rd_addr         memory read strobe and bin address (data returns next cycle)
//   rd_re, rd_im           memory read data, signed Q8.8
//   m_valid, m_ready       output beat handshake
//   m_bin, m_re, m_im      bin index and registered sample of the current beat
//   m_power, m_last        re*re+im*im of the current beat, last-bin flag
//   peak_bin, peak_power   peak of the last completed run
module fft256_spec_reader #(
  parameter int unsigned N  = 256,
  parameter int unsigned AW = 8,
  parameter int unsigned W  = 16
) (
  input  logic            ap_clk,
  input  logic            ap_rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [W-1:0]    rd_re,
  input  logic [W-1:0]    rd_im,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [AW-1:0]   m_bin,
  output logic [W-1:0]    m_re,
  output logic [W-1:0]    m_im,
  output logic [2*W-1:0]  m_power,
  output logic            m_last,
  output logic [AW-1:0]   peak_bin,
  output logic [2*W-1:0]  peak_power
);

  localparam logic [AW-1:0] LastBin = AW'(N - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StSend, StFinish} state_e;

  state_e state_q, state_d;

  logic            busy_q, done_q, m_valid_q, m_last_q;
  logic [AW-1:0]   k_q, m_bin_q, run_bin_q, peak_bin_q;
  logic [W-1:0]    m_re_q, m_im_q;
  logic [2*W-1:0]  m_power_q, run_pow_q, peak_pow_q;

  logic            accept, handshake;

  // Products of sign-extended operands; each square is non-negative and at most 2^(2W-2),
  // so their unsigned sum cannot overflow 2W bits.
  logic signed [2*W-1:0] re_ext, im_ext, re_sq, im_sq;
  logic        [2*W-1:0] power_d;

  assign re_ext  = {{W{rd_re[W-1]}}, rd_re};
  assign im_ext  = {{W{rd_im[W-1]}}, rd_im};
  assign re_sq   = re_ext * re_ext;
  assign im_sq   = im_ext * im_ext;
  assign power_d = re_sq + im_sq;

  // State register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch:  state_d = StLoad;
      StLoad:   state_d = StSend;
      StSend:   if (m_ready) state_d = m_last_q ? StFinish : StFetch;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Decoded outputs and strobes
  always_comb begin
    rd_en     = (state_q == StFetch);
    accept    = (state_q == StIdle) && start;
    handshake = (state_q == StSend) && m_ready;
  end

  // Datapath and registered outputs
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      k_q        <= '0;
      m_valid_q  <= 1'b0;
      m_bin_q    <= '0;
      m_re_q     <= '0;
      m_im_q     <= '0;
      m_power_q  <= '0;
      m_last_q   <= 1'b0;
      run_bin_q  <= '0;
      run_pow_q  <= '0;
      peak_bin_q <= '0;
      peak_pow_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        busy_q    <= 1'b1;
        k_q       <= '0;
        run_bin_q <= '0;
        run_pow_q <= '0;
      end
      if (state_q == StLoad) begin
        m_valid_q <= 1'b1;
        m_bin_q   <= k_q;
        m_re_q    <= rd_re;
        m_im_q    <= rd_im;
        m_power_q <= power_d;
        m_last_q  <= (k_q == LastBin);
      end
      if (handshake) begin
        m_valid_q <= 1'b0;
        if (!m_last_q) k_q <= k_q + AW'(1);
        // Strict compare keeps the lowest bin on ties.
        if (m_power_q > run_pow_q) begin
          run_pow_q <= m_power_q;
          run_bin_q <= m_bin_q;
        end
      end
      if (state_q == StFinish) begin
        peak_bin_q <= run_bin_q;
        peak_pow_q <= run_pow_q;
        done_q     <= 1'b1;
        busy_q     <= 1'b0;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_addr    = k_q;
  assign m_valid    = m_valid_q;
  assign m_bin      = m_bin_q;
  assign m_re       = m_re_q;
  assign m_im       = m_im_q;
  assign m_power    = m_power_q;
  assign m_last     = m_last_q;
  assign peak_bin   = peak_bin_q;
  assign peak_power = peak_pow_q;

endmodule

// File: doc/fft256_spec_reader.md
FFT256_SPEC_READER -- requirements
Module: fft256_spec_reader

Interface
REQ-001 SHALL have parameter N, default 256, number of FFT bins (power of two).
REQ-002 SHALL have parameter AW, default 8, bin address width (log2 N).
REQ-003 SHALL have parameter W, default 16, sample width, signed Q8.8.
REQ-004 SHALL have port ap_clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port ap_rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1, request to unload one spectrum.
REQ-007 SHALL have port busy, output, 1, high from accepted start until done.
REQ-008 SHALL have port done, output, 1, one-cycle pulse after the last bin handshake.
REQ-009 SHALL have port rd_en, output, 1, spectrum memory read strobe.
REQ-010 SHALL have port rd_addr, output, AW, bin index being read.
REQ-011 SHALL have port rd_re, input, W, real part, valid exactly 1 cycle after rd_en.
REQ-012 SHALL have port rd_im, input, W, imaginary part, same timing as rd_re.
REQ-013 SHALL have port m_valid, output, 1, output beat valid.
REQ-014 SHALL have port m_ready, input, 1, downstream accept.
REQ-015 SHALL have port m_bin, output, AW, bin index of the current beat.
REQ-016 SHALL have port m_re, output, W, registered real part of the current beat.
REQ-017 SHALL have port m_im, output, W, registered imaginary part of the current beat.
REQ-018 SHALL have port m_power, output, 2*W, unsigned re*re+im*im of the current beat.
REQ-019 SHALL have port m_last, output, 1, high on the beat with m_bin = N-1.
REQ-020 SHALL have port peak_bin, output, AW, bin index of maximum power in the last completed run.
REQ-021 SHALL have port peak_power, output, 2*W, power at peak_bin.

Function
REQ-022 SHALL implement FSM states IDLE, FETCH, LOAD, SEND, FINISH.
REQ-023 IDLE: start=1 SHALL set busy=1, clear bin counter k to 0, clear the running peak, and go to FETCH next cycle.
REQ-024 FETCH: SHALL assert rd_en=1 with rd_addr=k for exactly one cycle, then go to LOAD.
REQ-025 LOAD: SHALL register rd_re/rd_im into m_re/m_im, set m_bin=k, m_last=(k==N-1), m_power computed, m_valid=1, then go to SEND.
REQ-026 Power SHALL be computed as signed products sign-extended to 2*W and summed unsigned; -32768 squared twice gives 0x80000000 with no overflow.
REQ-027 SEND: m_valid SHALL stay 1 and m_bin/m_re/m_im/m_power/m_last SHALL stay stable while m_ready=0.
REQ-028 SEND with m_ready=1: SHALL drop m_valid next cycle; if m_last go to FINISH, else k<=k+1 and go to FETCH.
REQ-029 Throughput SHALL be one bin per 3 cycles with m_ready held high; a full run of N bins takes 3N cycles from FETCH entry to FINISH entry.
REQ-030 Running peak SHALL update on the SEND handshake only when m_power is strictly greater than the stored value; ties keep the lowest bin; initial stored value is bin 0, power 0.
REQ-031 FINISH: SHALL copy the running peak to peak_bin/peak_power, pulse done=1 for one cycle, clear busy, and go to IDLE.
REQ-032 peak_bin/peak_power SHALL hold their values until the next FINISH.
REQ-033 start while busy=1 SHALL be ignored and SHALL NOT restart or re-queue a run.
REQ-034 start sampled high in the FINISH cycle SHALL be ignored; start in the following IDLE cycle is accepted.
REQ-035 rd_en SHALL be 0 in all states other than FETCH; rd_addr SHALL hold k at all times.

Reset
REQ-036 ap_rst=1 SHALL force IDLE and clear busy, done, rd_en, rd_addr, m_valid, m_bin, m_re, m_im, m_power, m_last, peak_bin, and peak_power to 0 on the next edge.
REQ-037 Reset mid-run SHALL abort without a done pulse and without updating peak_bin/peak_power beyond the reset value 0.
REQ-038 ap_rst SHALL take priority over start and m_ready in the same cycle.

Verification
REQ-039 All-zero memory, m_ready=1, start pulse -> 256 beats each with m_power=0, m_last only on bin 255, done 768+2 cycles after start, peak_bin=0, peak_power=0.
REQ-040 Bin 13 re=0x0100, im=0, others zero -> beat 13 m_power=0x00010000, peak_bin=13, peak_power=0x00010000.
REQ-041 Bins 5 and 200 both re=0x0200, im=0x0200 -> both beats m_power=0x00080000, peak_bin=5.
REQ-042 Bin 7 re=im=0x8000, m_ready low for 10 cycles at bin 7 -> m_valid high and m_bin=7, m_power=0x80000000 stable for all 10 cycles, no rd_en pulse meanwhile, peak_bin=7.
REQ-043 ap_rst pulsed while m_bin=100 -> next cycle m_valid=0, busy=0, rd_en=0, no done pulse, peak outputs 0; new start then completes a full 256-beat run.
REQ-044 Second start pulse at bin 50 -> ignored; exactly 256 beats and one done pulse.
